// File: rtl/jk_cmd_seq.sv
// Queued JK flip-flop command sequencer: drives {j,k} for N cycles per command, then checks q_fb.
// Accept-to-drive latency is 2 cycles; cmd_ready drops when the FIFO is full (no pop bypass).
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_rpt,
  output logic                     j,
  output logic                     k,
  input  logic                     q_fb,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;

  state_t           r_state, w_state_nxt;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             w_full, w_empty, w_push, w_pop;
  logic [1:0]       w_head_op;
  logic [CNT_W-1:0] w_head_rpt, w_head_n;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_n_odd, r_first, r_q0, r_err, r_j, r_k;
  logic             w_exp, w_mismatch;

  assign w_full    = (r_fill == (AW+1)'(DEPTH));
  assign w_empty   = (r_fill == '0);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign {w_head_op, w_head_rpt} = r_mem[r_rd_ptr];
  assign w_head_n  = (w_head_rpt == '0) ? CNT_W'(1) : w_head_rpt;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Chain straight into the next command so queued work sees no IDLE gap.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_exp = 1'b0;
    case (r_op)
      2'b00: w_exp = r_q0;
      2'b01: w_exp = 1'b0;
      2'b10: w_exp = 1'b1;
      2'b11: w_exp = r_q0 ^ r_n_odd;
      default: w_exp = 1'b0;
    endcase
  end

  assign w_mismatch = (r_state == S_CHECK) && (q_fb != w_exp);

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_rpt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_cnt   <= '0;
      r_n_odd <= 1'b0;
      r_first <= 1'b0;
      r_q0    <= 1'b0;
      r_err   <= 1'b0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_op    <= w_head_op;
        r_cnt   <= w_head_n;
        r_n_odd <= w_head_n[0];
        r_first <= 1'b1;
      end else if (r_state == S_DRIVE) begin
        r_cnt   <= r_cnt - CNT_W'(1);
        r_first <= 1'b0;
      end
      // q_fb in the first drive cycle still shows the flop state before this command.
      if (r_state == S_DRIVE && r_first) r_q0 <= q_fb;
      if (w_mismatch)   r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
      {r_j, r_k} <= (w_state_nxt == S_DRIVE) ? (w_pop ? w_head_op : r_op) : 2'b00;
    end
  end

  assign j    = r_j;
  assign k    = r_k;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_CHECK);
  assign err  = r_err;
  assign fill = r_fill;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq with a behavioural JK flip-flop closing the q_fb loop.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, cmd_valid, cmd_ready, j, k, q_fb, busy, done, err, err_clr;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_rpt;
  logic [2:0]       fill;
  logic             q_ff, q_ld, q_ld_val, force0;

  int n_cmp = 0;
  int n_bad = 0;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rpt(cmd_rpt), .j(j), .k(k), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr), .fill(fill)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (q_ld) q_ff <= q_ld_val;
    else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  assign q_fb = force0 ? 1'b0 : q_ff;

  typedef struct {
    logic       q_init;
    logic [1:0] op;
    logic [3:0] rpt;
    int         n_exp;
    logic       q_exp;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] rpt;
  } cmd_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_q(input logic v);
    @(negedge clk);
    q_ld = 1'b1;
    q_ld_val = v;
    @(negedge clk);
    q_ld = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    bit  fin, jk_bad;
    load_q(v.q_init);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_rpt = v.rpt;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_t1_busy", idx), busy, 0);
    chk($sformatf("v%0d_t1_fill", idx), fill, 1);
    @(negedge clk);
    chk($sformatf("v%0d_t2_busy", idx), busy, 1);
    n = 0; fin = 0; jk_bad = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (done) fin = 1;
      else begin
        n++;
        if ({j, k} !== v.op) jk_bad = 1;
        @(negedge clk);
      end
    end
    chk($sformatf("v%0d_done_seen", idx), fin, 1);
    chk($sformatf("v%0d_drive_len", idx), n, v.n_exp);
    chk($sformatf("v%0d_drive_jk", idx), jk_bad, 0);
    chk($sformatf("v%0d_check_jk", idx), {j, k}, 0);
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), busy, 0);
    chk($sformatf("v%0d_err", idx), err, 0);
    chk($sformatf("v%0d_q", idx), q_fb, v.q_exp);
  endtask

  task automatic push_wait_done(input logic [1:0] op, input logic [3:0] rpt);
    cmd_valid = 1'b1; cmd_op = op; cmd_rpt = rpt;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done) break;
    end
    chk("wait_done", done, 1);
  endtask

  initial begin
    cmd_t       sched[6];
    logic [1:0] seg_jk[8];
    int         seg_n[8];
    logic [1:0] cur_jk;
    int         nseg, gap, cur_n, hits;
    bit         open, started, jk_bad;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rpt = '0;
    err_clr = 1'b0; force0 = 1'b0; q_ld = 1'b1; q_ld_val = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_fill", fill, 0);
    rst = 1'b0; q_ld = 1'b0;

    //        q0    op     rpt   N   q
    vecs[0] = '{1'b0, 2'b10, 4'd3, 3, 1'b1};
    vecs[1] = '{1'b0, 2'b11, 4'd3, 3, 1'b1};
    vecs[2] = '{1'b0, 2'b11, 4'd2, 2, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 4'd0, 1, 1'b1};
    vecs[4] = '{1'b1, 2'b01, 4'd1, 1, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 4'd2, 2, 1'b1};
    vecs[6] = '{1'b0, 2'b00, 4'd0, 1, 1'b0};
    vecs[7] = '{1'b1, 2'b11, 4'd15, 15, 1'b0};
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Fill the FIFO behind a long command; the sixth push must bounce.
    sched[0] = '{2'b10, 4'd15};
    sched[1] = '{2'b01, 4'd1};
    sched[2] = '{2'b11, 4'd2};
    sched[3] = '{2'b10, 4'd3};
    sched[4] = '{2'b11, 4'd1};
    sched[5] = '{2'b01, 4'd4};
    load_q(1'b0);
    nseg = 0; gap = 0; cur_n = 0; cur_jk = 2'b00; open = 0; started = 0; jk_bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (busy && !done) begin
        if (!open) begin
          open = 1; started = 1; cur_jk = {j, k}; cur_n = 1;
        end else begin
          cur_n++;
          if ({j, k} !== cur_jk) jk_bad = 1;
        end
      end else if (done) begin
        if (nseg < 8) begin
          seg_jk[nseg] = cur_jk;
          seg_n[nseg] = cur_n;
        end
        nseg++;
        open = 0;
      end else if (started && nseg < 5) gap++;
      if (c == 4) chk("full_ready_3", cmd_ready, 1);
      if (c == 5) begin
        chk("full_fill", fill, 4);
        chk("full_ready", cmd_ready, 0);
      end
      if (c == 6) chk("full_ignored_fill", fill, 4);
      if (c < 6) begin
        cmd_valid = 1'b1; cmd_op = sched[c].op; cmd_rpt = sched[c].rpt;
      end else cmd_valid = 1'b0;
    end
    chk("full_nseg", nseg, 5);
    for (int i = 0; i < 5 && i < nseg; i++) begin
      chk($sformatf("full_seg%0d_op", i), seg_jk[i], sched[i].op);
      chk($sformatf("full_seg%0d_len", i), seg_n[i], (sched[i].rpt == 0) ? 1 : sched[i].rpt);
    end
    chk("b2b_gap", gap, 0);
    chk("full_jk", jk_bad, 0);
    chk("full_err", err, 0);
    chk("full_q", q_fb, 0);

    // Error path: flop stuck at 0 while a set is driven.
    load_q(1'b0);
    force0 = 1'b1;
    push_wait_done(2'b10, 4'd2);
    chk("err_in_check", err, 0);
    @(negedge clk);
    chk("err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("err_held", err, 1);
    force0 = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);

    force0 = 1'b1;
    push_wait_done(2'b10, 4'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set_wins", err, 1);
    force0 = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared2", err, 0);

    // Reset in the second drive cycle of a 5-cycle toggle, with a push in the same cycle.
    load_q(1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (busy) break;
    end
    chk("rmid_drive1", busy, 1);
    @(negedge clk);
    chk("rmid_drive2_jk", {j, k}, 2'b11);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rpt = 4'd1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    chk("rmid_jk", {j, k}, 0);
    chk("rmid_fill", fill, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    chk("rmid_ready", cmd_ready, 1);
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy || done) hits++;
    end
    chk("rmid_no_activity", hits, 0);
    chk("rmid_q_kept", q_fb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; SHALL be a power of 2, >= 2.
REQ-002 Parameter CNT_W, default 4, width of the repeat-count field.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept; cmd_ready = !full, with no same-cycle pop bypass.
REQ-007 cmd_op  input  2  {j,k} encoding: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 cmd_rpt  input  CNT_W  number of drive cycles; value 0 SHALL be treated as 1.
REQ-009 j, k  output  1 each  registered drive to the downstream JK flip-flop.
REQ-010 q_fb  input  1  flip-flop q output, fed back for checking.
REQ-011 busy  output  1  high in DRIVE or CHECK.
REQ-012 done  output  1  one-cycle pulse in each CHECK cycle.
REQ-013 err  output  1  sticky mismatch flag.
REQ-014 err_clr  input  1  clears err.
REQ-015 fill  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Push on cycle with cmd_valid && cmd_ready; {cmd_op, cmd_rpt} SHALL be written at that edge.
REQ-017 Push and pop in the same cycle SHALL both take effect, leaving fill unchanged.
REQ-018 cmd_valid while full SHALL be ignored, with no change to FIFO state.
REQ-019 FSM states SHALL be IDLE, DRIVE and CHECK.
REQ-020 IDLE: if fill != 0, pop the head entry and go to DRIVE; otherwise stay in IDLE.
REQ-021 Pop SHALL load op into op_r and max(rpt,1) into cnt_r.
REQ-022 DRIVE: {j,k} = op_r for exactly max(rpt,1) consecutive cycles; cnt_r decrements each cycle; after the last cycle go to CHECK.
REQ-023 On the first DRIVE cycle, q_fb SHALL be captured as q0.
REQ-024 Expected value exp SHALL be: reset -> 0; set -> 1; hold -> q0; toggle -> q0 XOR (N odd), where N = max(rpt,1).
REQ-025 CHECK lasts one cycle with j=k=0 and done=1.
REQ-026 In CHECK, if q_fb != exp, err SHALL set on the next edge.
REQ-027 CHECK SHALL go to DRIVE with a pop if fill != 0, else to IDLE, so back-to-back commands incur no IDLE cycle.
REQ-028 Latency: a command accepted at edge t into an idle, empty block SHALL drive j/k starting in cycle t+2.
REQ-029 j and k SHALL be 0 in IDLE and CHECK.
REQ-030 err SHALL stay at 1 until err_clr or rst.
REQ-031 If err_clr and a mismatch occur in the same CHECK cycle, err SHALL end at 1 (set wins).
REQ-032 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-033 fill SHALL range 0..DEPTH inclusive.

Reset
REQ-034 On rst: FSM goes to IDLE; FIFO is flushed (fill = 0, pointers = 0).
REQ-035 On rst: j=0, k=0, busy=0, done=0, err=0, cmd_ready=1.
REQ-036 rst SHALL override all other inputs, including a push in the same cycle.
REQ-037 rst mid-DRIVE SHALL abort the command: no CHECK and no done pulse; the downstream FF keeps its last state.

Verification
REQ-038 Latency: empty, idle; push set, rpt=3 at edge t -> j=1,k=0 in cycles t+2..t+4; done in t+5; err=0 with q_fb=1.
REQ-039 Toggle parity: q_fb=0; toggle rpt=3 -> exp=1; toggle rpt=2 -> exp=0; rpt=0 -> one drive cycle, exp=1.
REQ-040 Full: DEPTH=4; 5 pushes with no drain -> cmd_ready=0 after the 4th, 5th ignored; fill=4; all 4 execute in order.
REQ-041 Back-to-back: 2 queued commands -> CHECK of the first is followed directly by DRIVE of the second, with no IDLE cycle.
REQ-042 Error path: force q_fb=0 during a set command -> err=1 after CHECK and held; err_clr -> err=0 on the next edge.
REQ-043 Reset mid-op: rst in the 2nd DRIVE cycle of rpt=5 -> next cycle j=k=0, fill=0, busy=0, no done pulse.
